leaf_uart_rx: RTL and testbench

- UART receiver for the serial link driven by the leaf_chip `tx` output: 8N1 framing, LSB first, 16x oversampling.
- Recovers bytes from an asynchronous serial line and buffers them in a small first-word-fall-through FIFO.
- Flags framing and overrun errors.
- Used as the bench/host-side peer of the chip UART, and as the reusable receive half for a future Wishbone-mapped UART peripheral in the user project area.

---
 rtl/leaf_uart_rx.sv | 172 +++++++++++++++++
 tb/tb_leaf_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start-edge aligned tick generator,
// sticky framing/overrun flags and a small first-word-fall-through receive FIFO.
module leaf_uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_full,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 err_clr
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_s1_q, rx_s2_q, rx_dly_q;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [SW-1:0]          smp_cnt_q, smp_cnt_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_err_q, overrun_err_d;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic tick, fall, push_req, frame_set;
    logic pop, full, push_ok, ovr_set;

    assign tick = (div_cnt_q == baud_div);
    assign fall = rx_dly_q & ~rx_s2_q;

    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Restarting the divider here centres every later sample on its bit.
                if (fall) begin
                    state_d   = S_START;
                    smp_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (smp_cnt_q == HALF_LAST) begin
                        smp_cnt_d = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        smp_cnt_d = smp_cnt_q + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (smp_cnt_q == FULL_LAST) begin
                        smp_cnt_d = '0;
                        shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IW'(1);
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + SW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (smp_cnt_q == FULL_LAST) begin
                        smp_cnt_d = '0;
                        state_d   = S_IDLE;
                        push_req  = rx_s2_q;
                        frame_set = ~rx_s2_q;
                    end else begin
                        smp_cnt_d = smp_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    always_comb begin
        pop           = rd_en & (count_q != '0);
        full          = (count_q == CNT_FULL);
        push_ok       = push_req & (~full | pop);
        ovr_set       = push_req & full & ~pop;
        wr_ptr_d      = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
        frame_err_d   = frame_set | (frame_err_q & ~err_clr);
        overrun_err_d = ovr_set | (overrun_err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_dly_q      <= 1'b1;
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            smp_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            rx_s1_q       <= rx;
            rx_s2_q       <= rx_s1_q;
            rx_dly_q      <= rx_s2_q;
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            smp_cnt_q     <= smp_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_valid    = (count_q != '0);
    assign rx_full     = full;
    assign rx_data     = rx_valid ? mem[rd_ptr_q] : '0;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_leaf_uart_rx.sv
// Scoreboard bench for leaf_uart_rx: stimulus queues expected bytes, a negedge
// monitor pops the FIFO and compares each head byte against the queue.
module tb_leaf_uart_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic        rd_en = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_full, frame_err, overrun_err;
    logic        err_clr = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    bit          auto_read = 1'b0;
    int          pops_req = 0;
    int          pops_done = 0;

    leaf_uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .baud_div   (baud_div),
        .rd_en      (rd_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_full    (rx_full),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the head whenever reading is enabled and compares it.
    always @(negedge clk) begin
        rd_en = 1'b0;
        if (rx_valid && (auto_read || pops_done < pops_req)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte actual=%02h required=none", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
            end
            rd_en = 1'b1;
            if (!auto_read) pops_done++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        int n;
        n = 16 * (int'(baud_div) + 1);
        @(posedge clk); #1 rx = 1'b0;
        repeat (n) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (n) @(posedge clk);
        end
        #1 rx = stop_v;
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rx_valid) break;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        @(posedge clk); #1;
        chk({name, "_valid"}, rx_valid, 1'b0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_full", rx_full, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_oerr", overrun_err, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        // 0x55 then 0xA3 at 16 clk/bit, including exact first-byte latency
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        fork
            send_byte(8'h55, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 chk("lat_before", rx_valid, 1'b0);
                @(posedge clk);
                #1 chk("lat_valid", rx_valid, 1'b1);
                chk("lat_data", rx_data, 8'h55);
            end
        join
        send_byte(8'hA3, 1'b1);
        repeat (4) @(posedge clk);
        chk("two_full", rx_full, 1'b0);
        pops_req += 2;
        wait_drain("t1");
        chk("t1_ferr", frame_err, 1'b0);
        chk("t1_oerr", overrun_err, 1'b0);

        // Divisor 3 (64 clk/bit)
        baud_div = 16'd3;
        auto_read = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_drain("t2");
        auto_read = 1'b0;
        baud_div = 16'd0;

        // Short low glitch
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_valid", rx_valid, 1'b0);
        chk("glitch_ferr", frame_err, 1'b0);

        // Bad stop bit followed by a long break, then a good frame
        send_byte(8'h3C, 1'b0);
        repeat (320) @(posedge clk);
        #1;
        chk("brk_ferr", frame_err, 1'b1);
        chk("brk_valid", rx_valid, 1'b0);
        pulse_clr();
        #1 chk("brk_clr", frame_err, 1'b0);
        repeat (320) @(posedge clk);
        #1 chk("brk_once", frame_err, 1'b0);
        rx = 1'b1;
        repeat (32) @(posedge clk);
        auto_read = 1'b1;
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_drain("t4");
        auto_read = 1'b0;
        chk("t4_ferr", frame_err, 1'b0);

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_full", rx_full, 1'b1);
        chk("ovr_flag", overrun_err, 1'b1);
        chk("ovr_head", rx_data, 8'h10);
        auto_read = 1'b1;
        wait_drain("t5a");
        auto_read = 1'b0;
        chk("t5a_full", rx_full, 1'b0);
        pulse_clr();
        #1 chk("ovr_clr", overrun_err, 1'b0);

        // Pop coincident with the fifth push
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        fork
            send_byte(8'h14, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 pops_req++;
                @(posedge clk);
                #1 chk("same_full", rx_full, 1'b1);
                chk("same_oerr", overrun_err, 1'b0);
                chk("same_head", rx_data, 8'h11);
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("t5b_oerr", overrun_err, 1'b0);
        auto_read = 1'b1;
        wait_drain("t5b");
        auto_read = 1'b0;

        // Reset in the middle of a frame
        auto_read = 1'b1;
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #1 reset = 1'b1;
                #1;
                chk("mid_valid", rx_valid, 1'b0);
                chk("mid_data", rx_data, 8'h00);
                chk("mid_full", rx_full, 1'b0);
                chk("mid_ferr", frame_err, 1'b0);
                chk("mid_oerr", overrun_err, 1'b0);
            end
        join
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("post_rst_valid", rx_valid, 1'b0);
        exp_q.push_back(8'hC7);
        send_byte(8'hC7, 1'b1);
        wait_drain("t6");
        auto_read = 1'b0;
        chk("t6_ferr", frame_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
